// File: rtl/seq_sm_mul_pkg.sv
// seq_sm_mul_pkg: shared ALU FSM encoding and flag-bit ordering
package seq_sm_mul_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int FLAG_ZF = 0;
  localparam int FLAG_SF = 1;
endpackage

// File: rtl/sm_normalize.sv
// sm_normalize: zero detect, -0 clear and optional two's-complement conversion
module sm_normalize #(
  parameter int MW = 4,
  parameter bit OUT_TC = 1'b0
) (
  input  logic          sign,
  input  logic [MW-1:0] mag,
  output logic [MW:0]   r,
  output logic          sf,
  output logic          zf
);
  assign zf = ~|mag;
  assign sf = sign & ~zf;
  assign r = OUT_TC ? (sf ? -{1'b0, mag} : {1'b0, mag}) : {sf, mag};
endmodule

// File: rtl/seq_sm_mul.sv
// seq_sm_mul: sequential shift-add sign-magnitude multiplier with start/done handshake
module seq_sm_mul
  import seq_sm_mul_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter bit OUT_TC = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-2:0] R,
  output logic               SF,
  output logic               ZF
);
  localparam int M = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2*M:0] acc, acc_nx;
  logic [M-1:0] mag_a;
  logic [M:0] sum;
  logic sign, last;
  logic [2*M:0] r_nx;
  logic [1:0] flags_nx;
  // Upper half carries one spare bit so the add never loses its carry.
  always_comb begin
    sum = acc[2*M:M] + {1'b0, mag_a};
    acc_nx = acc[0] ? {sum, acc[M-1:0]} >> 1 : acc >> 1;
    last = (state == RUN) && (cnt == CW'(1));
    state_nx = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  sm_normalize #(.MW(2*M), .OUT_TC(OUT_TC)) u_norm (
    .sign(sign),
    .mag (acc_nx[2*M-1:0]),
    .r   (r_nx),
    .sf  (flags_nx[FLAG_SF]),
    .zf  (flags_nx[FLAG_ZF])
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mag_a <= '0;
      sign <= 1'b0;
      done <= 1'b0;
      R <= '0;
      SF <= 1'b0;
      ZF <= 1'b0;
    end else begin
      state <= state_nx;
      done <= last;
      if (state == IDLE && start) begin
        cnt <= CW'(M);
        acc <= {{(M+1){1'b0}}, B[M-1:0]};
        mag_a <= A[M-1:0];
        sign <= A[M] ^ B[M];
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        acc <= acc_nx;
      end
      if (last) begin
        R <= r_nx;
        SF <= flags_nx[FLAG_SF];
        ZF <= flags_nx[FLAG_ZF];
      end
    end
  end
  assign busy = (state == RUN);
endmodule

// File: tb/tb_seq_sm_mul.sv
// tb_seq_sm_mul: scoreboard bench over three configurations (W3 SM, W3 TC, W8 SM)
module tb_seq_sm_mul;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st = 3'b000;
  logic [7:0] av [3];
  logic [7:0] bv [3];
  logic busy0, busy1, busy2, done0, done1, done2;
  logic sf0, sf1, sf2, zf0, zf1, zf2;
  logic [4:0] r0, r1;
  logic [14:0] r2;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int d;
    int issue;
    int due;
    logic [16:0] exp;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_sm_mul #(.WIDTH(3), .OUT_TC(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .A(av[0][2:0]), .B(bv[0][2:0]),
    .busy(busy0), .done(done0), .R(r0), .SF(sf0), .ZF(zf0));
  seq_sm_mul #(.WIDTH(3), .OUT_TC(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .A(av[1][2:0]), .B(bv[1][2:0]),
    .busy(busy1), .done(done1), .R(r1), .SF(sf1), .ZF(zf1));
  seq_sm_mul #(.WIDTH(8), .OUT_TC(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .A(av[2]), .B(bv[2]),
    .busy(busy2), .done(done2), .R(r2), .SF(sf2), .ZF(zf2));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: signed integer product, then encoded as {SF, ZF, R}.
  function automatic logic [16:0] model(int w, bit tc, logic [7:0] a, logic [7:0] b);
    int m, n, ma, mb, p, mag;
    logic sf, zf;
    logic [14:0] r;
    m = w - 1;
    n = 2 * w - 1;
    ma = int'(a) & ((1 << m) - 1);
    mb = int'(b) & ((1 << m) - 1);
    p = (a[m] ? -ma : ma) * (b[m] ? -mb : mb);
    mag = p < 0 ? -p : p;
    sf = p < 0;
    zf = p == 0;
    r = tc ? 15'(p & ((1 << n) - 1)) : 15'((int'(sf) << (n - 1)) | mag);
    return {sf, zf, r};
  endfunction

  function automatic int wid(int d);
    return d == 2 ? 8 : 3;
  endfunction

  function automatic logic [7:0] sm3(int v);
    return v < 0 ? 8'(4 | -v) : 8'(v);
  endfunction

  // Drive from a negedge; returns at the following negedge.
  task automatic issue(int d, logic [7:0] a, logic [7:0] b);
    exp_t e;
    st[d] = 1'b1;
    av[d] = a;
    bv[d] = b;
    e.d = d;
    e.issue = cyc;
    e.due = cyc + wid(d);
    e.exp = model(wid(d), d == 1, a, b);
    q.push_back(e);
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic b2b(int d, logic [7:0] a, logic [7:0] b);
    issue(d, a, b);
    repeat (wid(d) - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        logic dn, bz, eb;
        logic [16:0] got;
        dn = d == 0 ? done0 : d == 1 ? done1 : done2;
        bz = d == 0 ? busy0 : d == 1 ? busy1 : busy2;
        got = d == 0 ? {sf0, zf0, 10'd0, r0} : d == 1 ? {sf1, zf1, 10'd0, r1} : {sf2, zf2, r2};
        if (dn) begin
          if (q.size() == 0 || q[0].d != d) begin
            chk($sformatf("spurious_done_dut%0d", d), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("done_cycle_dut%0d", d), 32'(cyc), 32'(e.due));
            chk($sformatf("result_dut%0d", d), 32'(got), 32'(e.exp));
          end
        end else if (q.size() > 0 && q[0].d == d && cyc > q[0].due) begin
          chk($sformatf("missing_done_dut%0d", d), 32'(cyc), 32'(q[0].due));
          void'(q.pop_front());
        end
        eb = q.size() > 0 && q[0].d == d && cyc > q[0].issue && cyc < q[0].due;
        chk($sformatf("busy_dut%0d", d), 32'(bz), 32'(eb));
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      av[d] = '0;
      bv[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy0, done0, r0, sf0, zf0, busy1, done1, r1, sf1, zf1},
        32'd0);
    chk("reset_outputs_w8", {busy2, done2, r2, sf2, zf2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // Directed W3 sign-magnitude cases, then an exhaustive back-to-back sweep.
    b2b(0, 8'b111, 8'b011);
    b2b(0, 8'b110, 8'b111);
    b2b(0, 8'b100, 8'b011);
    for (int i = -3; i <= 3; i++)
      for (int j = -3; j <= 3; j++) b2b(0, sm3(i), sm3(j));
    repeat (4) @(negedge clk);
    b2b(1, sm3(-3), sm3(3));
    b2b(1, sm3(3), sm3(3));
    for (int k = 0; k < 10; k++) b2b(1, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
    repeat (4) @(negedge clk);
    // W8: a start mid-run plus operand churn must not disturb the result.
    issue(2, 8'hFF, 8'h7F);
    @(negedge clk);
    @(negedge clk);
    st[2] = 1'b1;
    av[2] = 8'h05;
    bv[2] = 8'h83;
    @(negedge clk);
    st[2] = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 20; k++) b2b(2, 8'($urandom), 8'($urandom));
    b2b(2, 8'h80, 8'hFF);
    repeat (4) @(negedge clk);
    // Reset in cycle 2 of a W3 op: outputs clear, no done, then a clean restart.
    issue(0, 8'b111, 8'b011);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("abort_outputs", {busy0, done0, r0, sf0, zf0}, 32'd0);
    repeat (5) @(negedge clk);
    b2b(0, 8'b010, 8'b111);
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
